// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_forward_ctrl_pkg;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0] src1;
        logic [3:0] src2;
        logic       use1;
        logic       use2;
        logic [3:0] dest;
        logic       wb;
        logic       mr;
        logic       mw;
    } exe_shadow_t;

    typedef struct packed {
        logic [3:0] dest;
        logic       wb;
        logic       mem_acc;
    } mem_shadow_t;

    typedef struct packed {
        logic [3:0] dest;
        logic       wb;
    } wb_shadow_t;

    // MEM result wins over WB when both stages write the same register.
    function automatic logic [1:0] fwd_sel(
        input logic [3:0]  src,
        input logic        use_src,
        input mem_shadow_t m,
        input wb_shadow_t  w
    );
        if (use_src && m.wb && (src == m.dest)) begin
            return SEL_MEM;
        end else if (w.wb && (src == w.dest)) begin
            return SEL_WB;
        end
        return SEL_RF;
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_hazard_detect.sv
// RAW hazard detection between the instruction in ID and the EXE/MEM shadows.
module hazard_detect
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int FWD_EN = 1
) (
    input  logic [3:0] src1,
    input  logic [3:0] src2,
    input  logic       use_src1,
    input  logic       use_src2,
    input  logic [3:0] exe_dest,
    input  logic       exe_wb,
    input  logic       exe_mr,
    input  logic [3:0] mem_dest,
    input  logic       mem_wb,
    output logic       hazard
);

    logic exe_hit;
    logic mem_hit;

    assign exe_hit = exe_wb && ((use_src1 && (src1 == exe_dest)) ||
                                (use_src2 && (src2 == exe_dest)));
    assign mem_hit = mem_wb && ((use_src1 && (src1 == mem_dest)) ||
                                (use_src2 && (src2 == mem_dest)));

    // With forwarding only a load still in EXE cannot supply its data in time.
    assign hazard = (FWD_EN != 0) ? (exe_hit && exe_mr) : (exe_hit || mem_hit);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Pipeline scheduler: operand forwarding selects plus stall/flush/freeze control.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int FWD_EN   = 1,
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_use_src1,
    input  logic             id_use_src2,
    input  logic [3:0]       id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic             id_mem_w_en,
    input  logic             branch_taken,
    input  logic             sram_ready,
    output logic [1:0]       sel_src1,
    output logic [1:0]       sel_src2,
    output logic             stall,
    output logic             flush,
    output logic             freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t            state;
    state_t            state_next;
    exe_shadow_t       exe_sh;
    mem_shadow_t       mem_sh;
    wb_shadow_t        wb_sh;
    exe_shadow_t       id_entry;
    logic              hazard;
    logic [WAIT_W-1:0] wait_cnt;

    hazard_detect #(
        .FWD_EN (FWD_EN)
    ) u_hazard_detect (
        .src1     (id_src1),
        .src2     (id_src2),
        .use_src1 (id_use_src1),
        .use_src2 (id_use_src2),
        .exe_dest (exe_sh.dest),
        .exe_wb   (exe_sh.wb),
        .exe_mr   (exe_sh.mr),
        .mem_dest (mem_sh.dest),
        .mem_wb   (mem_sh.wb),
        .hazard   (hazard)
    );

    always_comb begin
        sel_src1 = SEL_RF;
        sel_src2 = SEL_RF;
        if (FWD_EN != 0) begin
            sel_src1 = fwd_sel(exe_sh.src1, exe_sh.use1, mem_sh, wb_sh);
            sel_src2 = fwd_sel(exe_sh.src2, exe_sh.use2, mem_sh, wb_sh);
        end
    end

    // Freeze outranks flush, which outranks stall.
    always_comb begin
        state_next = state;
        freeze     = mem_sh.mem_acc && !sram_ready;
        flush      = branch_taken && !freeze;
        stall      = hazard && id_valid && !freeze && !branch_taken;
        case (state)
            RUN:      if (freeze) state_next = MEM_WAIT;
            MEM_WAIT: if (sram_ready) state_next = RUN;
            default:  state_next = RUN;
        endcase
    end

    always_comb begin
        id_entry = '0;
        if (id_valid && !flush && !stall) begin
            id_entry.src1 = id_src1;
            id_entry.src2 = id_src2;
            id_entry.use1 = id_use_src1;
            id_entry.use2 = id_use_src2;
            id_entry.dest = id_dest;
            id_entry.wb   = id_wb_en;
            id_entry.mr   = id_mem_r_en;
            id_entry.mw   = id_mem_w_en;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_sh <= '0;
            mem_sh <= '0;
            wb_sh  <= '0;
        end else if (!freeze) begin
            wb_sh.dest     <= mem_sh.dest;
            wb_sh.wb       <= mem_sh.wb;
            mem_sh.dest    <= exe_sh.dest;
            mem_sh.wb      <= exe_sh.wb;
            mem_sh.mem_acc <= exe_sh.mr | exe_sh.mw;
            exe_sh         <= id_entry;
        end
    end

    // Only cycles still waiting on the SRAM count; the completing cycle does not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (state == RUN) begin
            if (state_next == MEM_WAIT) wait_cnt <= '0;
        end else if (!sram_ready) begin
            if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt >= WAIT_LAST) mem_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if ((stall || freeze) && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: a forwarding instance and a non-forwarding one.
`timescale 1ns/1ps
module tb_hazard_forward_ctrl;
    import hazard_forward_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid, id_use_src1, id_use_src2, id_wb_en, id_mem_r_en, id_mem_w_en;
    logic [3:0] id_src1, id_src2, id_dest;
    logic       branch_taken, sram_ready;

    logic [1:0]  a_sel1, a_sel2, b_sel1, b_sel2;
    logic        a_stall, a_flush, a_freeze, a_tmo;
    logic        b_stall, b_flush, b_freeze, b_tmo;
    logic [15:0] a_cnt;
    logic [2:0]  b_cnt;

    hazard_forward_ctrl #(.FWD_EN(1), .MAX_WAIT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
        .branch_taken(branch_taken), .sram_ready(sram_ready),
        .sel_src1(a_sel1), .sel_src2(a_sel2), .stall(a_stall), .flush(a_flush),
        .freeze(a_freeze), .mem_timeout(a_tmo), .stall_cycles(a_cnt)
    );

    hazard_forward_ctrl #(.FWD_EN(0), .MAX_WAIT(64), .CNT_W(3)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
        .branch_taken(branch_taken), .sram_ready(sram_ready),
        .sel_src1(b_sel1), .sel_src2(b_sel2), .stall(b_stall), .flush(b_flush),
        .freeze(b_freeze), .mem_timeout(b_tmo), .stall_cycles(b_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] s1, s2;
        logic       u1, u2;
        logic [3:0] d;
        logic       wb, mr, mw, br, rdy;
        logic [1:0] sel1, sel2;
        logic       stall, flush, freeze;
    } vec_t;

    localparam int NV = 17;
    vec_t vt[NV];
    int   checks  = 0;
    int   errors  = 0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input int v, s1, s2, u1, u2, d, wb, mr, mw, br, rdy,
                                 sel1, sel2, st, fl, fz);
        vec_t r;
        r.v = v[0]; r.s1 = s1[3:0]; r.s2 = s2[3:0]; r.u1 = u1[0]; r.u2 = u2[0];
        r.d = d[3:0]; r.wb = wb[0]; r.mr = mr[0]; r.mw = mw[0]; r.br = br[0]; r.rdy = rdy[0];
        r.sel1 = sel1[1:0]; r.sel2 = sel2[1:0]; r.stall = st[0]; r.flush = fl[0]; r.freeze = fz[0];
        return r;
    endfunction

    task automatic drive(input int v, s1, s2, u1, u2, d, wb, mr, mw);
        id_valid = v[0]; id_src1 = s1[3:0]; id_src2 = s2[3:0];
        id_use_src1 = u1[0]; id_use_src2 = u2[0]; id_dest = d[3:0];
        id_wb_en = wb[0]; id_mem_r_en = mr[0]; id_mem_w_en = mw[0];
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nop();
        branch_taken = 1'b0;
        sram_ready   = 1'b1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        //         v  s1 s2 u1 u2 d  wb mr mw br rdy  sel1 sel2 st fl fz
        vt[0]  = mkv(1, 2, 3, 1, 1, 1, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0); // ADD R1
        vt[1]  = mkv(1, 1, 3, 1, 1, 2, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0); // SUB R2,R1,R3
        vt[2]  = mkv(1, 1, 8, 1, 1, 7, 1, 0, 0, 0, 1,  1, 0, 0, 0, 0); // SUB in EXE, R1 from MEM
        vt[3]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  2, 0, 0, 0, 0); // reader in EXE, R1 from WB
        vt[4]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
        vt[5]  = mkv(1, 9, 0, 1, 0, 4, 1, 1, 0, 0, 1,  0, 0, 0, 0, 0); // LDR R4
        vt[6]  = mkv(1, 4, 6, 1, 1, 5, 1, 0, 0, 0, 1,  0, 0, 1, 0, 0); // ADD R5,R4,R6 load-use
        vt[7]  = mkv(1, 4, 6, 1, 1, 5, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0); // held, released
        vt[8]  = mkv(1, 10, 5, 1, 1, 0, 0, 0, 1, 0, 1, 2, 0, 0, 0, 0); // STR R5; ADD gets R4 from WB
        vt[9]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0); // STR src2 from MEM
        vt[10] = mkv(1, 9, 0, 1, 0, 3, 1, 1, 0, 0, 1,  0, 0, 0, 0, 0); // LDR R3
        vt[11] = mkv(1, 3, 3, 1, 1, 6, 1, 0, 0, 1, 1,  0, 0, 0, 1, 0); // branch beats load-use
        vt[12] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0); // EXE holds a bubble
        vt[13] = mkv(1, 2, 1, 1, 1, 0, 0, 0, 1, 0, 1,  0, 0, 0, 0, 0); // STR R1
        vt[14] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
        vt[15] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1); // branch under freeze
        vt[16] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);

        #1;
        nop();
        branch_taken = 1'b0;
        sram_ready   = 1'b1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_sel1", 16'(a_sel1), 16'(SEL_RF));
        chk("rst_a_stall", 16'(a_stall), 16'd0);
        chk("rst_a_flush", 16'(a_flush), 16'd0);
        chk("rst_a_freeze", 16'(a_freeze), 16'd0);
        chk("rst_a_tmo", 16'(a_tmo), 16'd0);
        chk("rst_a_cnt", a_cnt, 16'd0);
        chk("rst_b_cnt", 16'(b_cnt), 16'd0);
        rst = 1'b1;

        for (int k = 0; k < NV; k++) begin
            drive(vt[k].v, vt[k].s1, vt[k].s2, vt[k].u1, vt[k].u2, vt[k].d,
                  vt[k].wb, vt[k].mr, vt[k].mw);
            branch_taken = vt[k].br;
            sram_ready   = vt[k].rdy;
            #2;
            chk($sformatf("row%0d_sel1", k), 16'(a_sel1), 16'(vt[k].sel1));
            chk($sformatf("row%0d_sel2", k), 16'(a_sel2), 16'(vt[k].sel2));
            chk($sformatf("row%0d_stall", k), 16'(a_stall), 16'(vt[k].stall));
            chk($sformatf("row%0d_flush", k), 16'(a_flush), 16'(vt[k].flush));
            chk($sformatf("row%0d_freeze", k), 16'(a_freeze), 16'(vt[k].freeze));
            chk($sformatf("row%0d_cnt", k), a_cnt, 16'(exp_cnt));
            if (vt[k].stall || vt[k].freeze) exp_cnt++;
            step();
        end
        branch_taken = 1'b0;

        // Store reaches MEM, then SRAM stalls for 5 cycles while ADD R11 waits in ID.
        drive(1, 10, 5, 1, 1, 0, 0, 0, 1);
        sram_ready = 1'b1;
        step();
        nop();
        step();
        drive(1, 5, 5, 1, 1, 11, 1, 0, 0);
        sram_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk($sformatf("frz%0d_freeze", i), 16'(a_freeze), 16'd1);
            chk($sformatf("frz%0d_stall", i), 16'(a_stall), 16'd0);
            chk($sformatf("frz%0d_tmo", i), 16'(a_tmo), 16'd0);
            step();
        end
        exp_cnt += 5;
        sram_ready = 1'b1;
        #2;
        chk("frz_release", 16'(a_freeze), 16'd0);
        chk("frz_tmo_set", 16'(a_tmo), 16'd1);
        chk("frz_cnt", a_cnt, 16'(exp_cnt));
        step();
        drive(1, 11, 1, 1, 1, 12, 1, 0, 0);
        #2;
        chk("tmo_sticky1", 16'(a_tmo), 16'd1);
        step();
        nop();
        #2;
        chk("held_add_fwd_mem", 16'(a_sel1), 16'(SEL_MEM));
        chk("tmo_sticky2", 16'(a_tmo), 16'd1);
        step();

        // Non-forwarding instance: load-use stalls twice, selects stay at register file.
        do_reset();
        drive(1, 9, 0, 1, 0, 4, 1, 1, 0);
        #2;
        chk("f0_stall", 16'(b_stall), 16'd0);
        step();
        drive(1, 4, 6, 1, 1, 5, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("f%0d_stall", i + 1), 16'(b_stall), (i < 2) ? 16'd1 : 16'd0);
            chk($sformatf("f%0d_sel1", i + 1), 16'(b_sel1), 16'(SEL_RF));
            step();
        end
        nop();
        #2;
        chk("f4_sel1", 16'(b_sel1), 16'(SEL_RF));
        chk("f4_sel2", 16'(b_sel2), 16'(SEL_RF));
        chk("f4_cnt", 16'(b_cnt), 16'd2);
        chk("f4_a_cnt", a_cnt, 16'd1);
        step();

        // Both instances freeze on a store; 3-bit counter saturates, then reset mid-wait.
        drive(1, 10, 7, 1, 1, 0, 0, 0, 1);
        step();
        nop();
        step();
        sram_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #2;
            chk($sformatf("sat%0d_b_freeze", i), 16'(b_freeze), 16'd1);
            chk($sformatf("sat%0d_a_freeze", i), 16'(a_freeze), 16'd1);
            if (i < 6) step();
        end
        chk("sat_b_cnt", 16'(b_cnt), 16'd7);
        chk("sat_a_cnt", a_cnt, 16'd7);
        chk("sat_a_tmo", 16'(a_tmo), 16'd1);
        chk("sat_a_state", 16'(dut.state), 16'(MEM_WAIT));
        rst = 1'b0;
        #1;
        chk("arst_a_freeze", 16'(a_freeze), 16'd0);
        chk("arst_b_freeze", 16'(b_freeze), 16'd0);
        chk("arst_a_cnt", a_cnt, 16'd0);
        chk("arst_b_cnt", 16'(b_cnt), 16'd0);
        chk("arst_a_tmo", 16'(a_tmo), 16'd0);
        chk("arst_a_sel1", 16'(a_sel1), 16'(SEL_RF));
        chk("arst_a_state", 16'(dut.state), 16'(RUN));
        chk("arst_b_state", 16'(dut0.state), 16'(RUN));
        step();
        rst = 1'b1;
        sram_ready = 1'b1;
        #2;
        chk("post_rst_freeze", 16'(a_freeze), 16'd0);
        chk("post_rst_stall", 16'(a_stall), 16'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
